// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared sizing constants and helpers for the level-tracking RAM FIFO
package ram_fifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 12;
  localparam int DEF_AE_TH = 4;

  // Word capacity for a given address width.
  function automatic int capacity(input int depth);
    return 1 << depth;
  endfunction

  // The level counter needs one extra bit to represent a completely full array.
  function automatic int level_width(input int depth);
    return depth + 1;
  endfunction

  // Default almost_full threshold: four words below capacity.
  function automatic int def_af_th(input int depth);
    return capacity(depth) - 4;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [DEPTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];

  // Write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port returns the old word on a same-address write (read-first).
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_fifo_level.sv
// rtl/ram_fifo_level.sv - RAM-backed FIFO with level counter, threshold flags and sticky errors
module ram_fifo_level
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_TH = def_af_th(DEPTH),
  parameter int AE_TH = DEF_AE_TH
) (
  input  logic               clk,
  input  logic               res,
  input  logic               flush,
  input  logic               shift_in,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               shift_out,
  input  logic               clr_err,
  output logic [WIDTH-1:0]   rdata,
  output logic               rvalid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [DEPTH:0]     level,
  output logic               overflow,
  output logic               underflow
);

  localparam int LW = level_width(DEPTH);

  localparam logic [LW-1:0]    CAP_L   = LW'(capacity(DEPTH));
  localparam logic [LW-1:0]    AF_L    = LW'(AF_TH);
  localparam logic [LW-1:0]    AE_L    = LW'(AE_TH);
  localparam logic [LW-1:0]    ONE_L   = LW'(1);
  localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);

  if (!((AE_TH < AF_TH) && (AF_TH <= capacity(DEPTH)))) begin : g_bad_thresholds
    $error("ram_fifo_level: thresholds must satisfy AE_TH < AF_TH <= 2**DEPTH");
  end

  logic [DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q, level_nxt;
  logic             full_q, empty_q, afull_q, aempty_q;
  logic             rvalid_q, ovf_q, unf_q;
  logic [WIDTH-1:0] ram_q, rdata_hold;
  logic             req_ok, wr_acc, rd_acc, ovf_set, unf_set;

  // Request qualification: reset beats flush, flush beats shifting.
  always_comb begin
    req_ok  = !res && !flush;
    wr_acc  = req_ok && shift_in && (!full_q || shift_out);
    rd_acc  = req_ok && shift_out && !empty_q;
    ovf_set = req_ok && shift_in && full_q && !shift_out;
    unf_set = req_ok && shift_out && empty_q;
  end

  // Next level: cleared by reset/flush, otherwise net of accepted write and read.
  always_comb begin
    level_nxt = level_q;
    if (res || flush)             level_nxt = '0;
    else if (wr_acc && !rd_acc)   level_nxt = level_q + ONE_L;
    else if (rd_acc && !wr_acc)   level_nxt = level_q - ONE_L;
  end

  // Pointers advance on accepted operations and wrap naturally at 2**DEPTH.
  always_ff @(posedge clk) begin
    if (res || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Level and status flags registered together so they always agree.
  always_ff @(posedge clk) begin
    level_q  <= level_nxt;
    full_q   <= (level_nxt == CAP_L);
    empty_q  <= (level_nxt == '0);
    afull_q  <= (level_nxt >= AF_L);
    aempty_q <= (level_nxt <= AE_L);
  end

  // Read valid pulses for one cycle after each accepted read.
  always_ff @(posedge clk) begin
    if (res) rvalid_q <= 1'b0;
    else     rvalid_q <= rd_acc;
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (res) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set)      ovf_q <= 1'b1;
      else if (clr_err) ovf_q <= 1'b0;
      if (unf_set)      unf_q <= 1'b1;
      else if (clr_err) unf_q <= 1'b0;
    end
  end

  // Holding register so rdata is resettable and stable between reads.
  always_ff @(posedge clk) begin
    if (res)           rdata_hold <= '0;
    else if (rvalid_q) rdata_hold <= ram_q;
  end

  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  assign rdata        = rvalid_q ? ram_q : rdata_hold;
  assign rvalid       = rvalid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
